interrupt_acknowledge_sequencer: RTL and testbench
==================================================

INTERRUPT_ACKNOWLEDGE_SEQUENCER -- requirements
Module: interrupt_acknowledge_sequencer

Interface
REQ-001 Parameter PULSE_CYCLES, default 2: clocks interrupt_acknowledge_n is held low per pulse; legal range 1..15.
REQ-002 Parameter GAP_CYCLES, default 2: clocks interrupt_acknowledge_n is held high between pulses; legal range 1..15.
REQ-003 Parameter MODE_8086, default 1: 1 = two-pulse 8086 sequence; 0 = three-pulse 8080 CALL sequence.
REQ-004 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port interrupt_to_cpu, input, 1: INT from the PIC; asynchronous to clock.
REQ-007 Port interrupt_enable, input, 1: core interrupt-enable flag; gates the start of a sequence.
REQ-008 Port interrupt_acknowledge_n, output, 1: INTA strobe to the PIC; registered.
REQ-009 Port data_bus_in, input, 8: byte driven by the PIC during INTA.
REQ-010 Port data_bus_io, input, 1: PIC bus direction; 0 = PIC driving data_bus_in.
REQ-011 Port vector_valid, output, 1: captured result available to the core.
REQ-012 Port vector_ready, input, 1: core accepts the result.
REQ-013 Port vector, output, 8: 8086 type byte, or the 8080 opcode byte.
REQ-014 Port vector_address, output, 16: 8080 CALL target {byte3, byte2}; 0 in 8086 mode.
REQ-015 Port vector_error, output, 1: at least one sample in this sequence was taken with data_bus_io = 1.
REQ-016 Port busy, output, 1: high in every state except IDLE.

Function
REQ-017 interrupt_to_cpu SHALL pass through a two-flop synchronizer; only the synchronized value (int_s) is used.
REQ-018 The FSM SHALL have exactly four states: IDLE, PULSE, GAP, PRESENT.
REQ-019 IDLE -> PULSE when int_s = 1 and interrupt_enable = 1; pulse index = 0, cycle counter = 0.
REQ-020 In PULSE, interrupt_acknowledge_n SHALL be 0.
- PULSE lasts exactly PULSE_CYCLES clocks.
- On its last clock edge, the PULSE -> GAP or PULSE -> PRESENT transition occurs.
REQ-021 In GAP, interrupt_acknowledge_n SHALL be 1 for exactly GAP_CYCLES clocks, then GAP -> PULSE with pulse index + 1.
REQ-022 Pulse count SHALL be 2 (MODE_8086 = 1) or 3 (MODE_8086 = 0); the final pulse goes directly to PRESENT with no trailing GAP.
REQ-023 Data sampling SHALL occur on the edge that ends a pulse (interrupt_acknowledge_n rising), as follows:
- 8086 mode: pulse 0 is not sampled; pulse 1 is sampled into vector.
- 8080 mode: pulse 0 -> vector, pulse 1 -> vector_address[7:0], pulse 2 -> vector_address[15:8].
REQ-024 vector_error SHALL be cleared on entry to PULSE from IDLE, and set if data_bus_io = 1 at any sampling edge.
REQ-025 In PRESENT, vector_valid SHALL be 1, and vector, vector_address and vector_error SHALL be held stable.
REQ-026 PRESENT -> IDLE on the edge where vector_valid = 1 and vector_ready = 1; vector_valid is 0 the next cycle.
- Outputs retain their last values until the next capture.
REQ-027 A new sequence SHALL NOT start on the same edge as a transfer; IDLE re-evaluates int_s from the following cycle.
REQ-028 int_s or interrupt_enable dropping during PULSE or GAP SHALL NOT abort the sequence; it always completes.
REQ-029 Latency with INT high before edge E0 and PULSE_CYCLES = GAP_CYCLES = 2 in 8086 mode:
- interrupt_acknowledge_n is low after E2, high after E4, low after E6.
- Vector sampled at E8; vector_valid high after E8.
REQ-030 Counters SHALL be 4 bits wide; the pulse index SHALL be 2 bits wide and SHALL never exceed 2.

Reset
REQ-031 While reset_n = 0, outputs SHALL be:
- interrupt_acknowledge_n = 1
- vector_valid = 0, busy = 0, vector_error = 0
- vector = 8'h00, vector_address = 16'h0000
- synchronizer flops = 0, state = IDLE
REQ-032 Reset asserted mid-PULSE SHALL force interrupt_acknowledge_n high asynchronously, without waiting for a clock edge.
REQ-033 After reset release, a sequence SHALL start only via REQ-019, with the full synchronizer latency applied.

Verification
REQ-034 8086 mode, defaults:
- Stimulus: interrupt_enable = 1; INT rises; PIC drives 8'h4A on pulse 1 with data_bus_io = 0; vector_ready = 1.
- Response: exactly two 2-cycle low pulses separated by 2 high cycles; vector = 8'h4A, vector_error = 0, vector_valid high for one cycle.
REQ-035 8080 mode:
- Stimulus: PIC returns 8'hCD, 8'h34, 8'h12.
- Response: three pulses; vector = 8'hCD, vector_address = 16'h1234, valid held until vector_ready.
REQ-036 Backpressure:
- Stimulus: vector_ready = 0 for 10 cycles while INT stays high.
- Response: vector_valid and vector remain stable; no further interrupt_acknowledge_n pulses until one cycle after the transfer.
REQ-037 Gating and abort:
- Stimulus: interrupt_enable = 0 with INT high -> response: no pulse.
- Stimulus: INT drops after the first pulse -> response: the second pulse still occurs.
REQ-038 Bus error:
- Stimulus: data_bus_io = 1 on the sampling edge.
- Response: vector_error = 1 with vector_valid; the next clean sequence returns vector_error = 0.
REQ-039 Reset:
- Stimulus: reset_n low during the second pulse.
- Response: interrupt_acknowledge_n immediately 1, all outputs at REQ-031 values, and a clean sequence after release.

Source files
------------

// File: rtl/interrupt_acknowledge_sequencer.sv
// Purpose: generates the 8086 (two-pulse) or 8080 CALL (three-pulse) INTA
//          sequence toward a PIC, captures the returned bytes and presents them.
// Latency: INT -> first INTA low after 3 edges (2-flop sync + IDLE decision);
//          result valid on the edge that ends the final pulse.
// Backpressure: result is held in PRESENT until vector_ready; no new sequence
//          starts until the cycle after the transfer.
//
// Ports:
//   clock, reset_n            : clock and asynchronous active-low reset
//   interrupt_to_cpu          : asynchronous INT from the PIC
//   interrupt_enable          : gates the start of a sequence only
//   interrupt_acknowledge_n   : registered INTA strobe to the PIC
//   data_bus_in, data_bus_io  : PIC data byte and bus direction (0 = PIC drives)
//   vector_valid/vector_ready : result handshake toward the core
//   vector, vector_address    : 8086 type byte / 8080 opcode and CALL target
//   vector_error              : a sample in this sequence saw data_bus_io = 1
//   busy                      : sequencer is not idle

module interrupt_acknowledge_sequencer #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int MODE_8086    = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        interrupt_to_cpu,
  input  logic        interrupt_enable,
  output logic        interrupt_acknowledge_n,
  input  logic [7:0]  data_bus_in,
  input  logic        data_bus_io,
  output logic        vector_valid,
  input  logic        vector_ready,
  output logic [7:0]  vector,
  output logic [15:0] vector_address,
  output logic        vector_error,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;
  localparam logic [1:0] ST_PRESENT = 2'd3;

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);
  // Index of the final pulse: it goes straight to PRESENT with no trailing gap.
  localparam logic [1:0] LAST_PULSE = (MODE_8086 != 0) ? 2'd1 : 2'd2;

  logic       int_meta;
  logic       int_s;
  logic [1:0] state;
  logic [3:0] cycle_cnt;
  logic [1:0] pulse_idx;
  logic       sample_en;

  // In 8086 mode the first pulse is only a bus-freeze cycle; its data is ignored.
  assign sample_en = (MODE_8086 != 0) ? (pulse_idx == 2'd1) : 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      int_meta <= 1'b0;
      int_s    <= 1'b0;
    end else begin
      int_meta <= interrupt_to_cpu;
      int_s    <= int_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= ST_IDLE;
      cycle_cnt               <= 4'd0;
      pulse_idx               <= 2'd0;
      interrupt_acknowledge_n <= 1'b1;
      vector                  <= 8'h00;
      vector_address          <= 16'h0000;
      vector_error            <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (int_s && interrupt_enable) begin
            state                   <= ST_PULSE;
            cycle_cnt               <= 4'd0;
            pulse_idx               <= 2'd0;
            interrupt_acknowledge_n <= 1'b0;
            vector_error            <= 1'b0;
          end
        end
        ST_PULSE: begin
          if (cycle_cnt == PULSE_LAST) begin
            // This edge raises INTA: the PIC byte is captured here.
            cycle_cnt               <= 4'd0;
            interrupt_acknowledge_n <= 1'b1;
            state                   <= (pulse_idx == LAST_PULSE) ? ST_PRESENT : ST_GAP;
            if (sample_en) begin
              if (data_bus_io) begin
                vector_error <= 1'b1;
              end
              if ((MODE_8086 != 0) || (pulse_idx == 2'd0)) begin
                vector <= data_bus_in;
              end else if (pulse_idx == 2'd1) begin
                vector_address[7:0] <= data_bus_in;
              end else begin
                vector_address[15:8] <= data_bus_in;
              end
            end
          end else begin
            cycle_cnt <= cycle_cnt + 4'd1;
          end
        end
        ST_GAP: begin
          if (cycle_cnt == GAP_LAST) begin
            cycle_cnt               <= 4'd0;
            pulse_idx               <= pulse_idx + 2'd1;
            interrupt_acknowledge_n <= 1'b0;
            state                   <= ST_PULSE;
          end else begin
            cycle_cnt <= cycle_cnt + 4'd1;
          end
        end
        ST_PRESENT: begin
          // Returning to IDLE here means the next start is decided one edge later.
          if (vector_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign vector_valid = (state == ST_PRESENT);
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// Purpose: directed bench for the INTA sequencer in 8086 and 8080 modes.
// Latency: checks the INT-to-INTA timing and pulse/gap widths cycle by cycle.
// Backpressure: holds vector_ready low and checks the result stays presented.

module tb_interrupt_acknowledge_sequencer;

  typedef struct {
    logic [7:0]  vec;
    logic [15:0] addr;
    logic        err;
    int          pulses;
    int          vrun;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic int_en  = 1'b0;

  logic       int_in [2];
  logic       ready  [2];
  logic       io     [2];
  logic [7:0] din    [2];

  logic        inta0, inta1, valid0, valid1, err0, err1, busy0, busy1;
  logic [7:0]  vec0, vec1;
  logic [15:0] addr0, addr1;

  logic inta_a [2];
  logic valid_a[2];
  logic busy_a [2];
  assign inta_a[0] = inta0;   assign inta_a[1] = inta1;
  assign valid_a[0] = valid0; assign valid_a[1] = valid1;
  assign busy_a[0] = busy0;   assign busy_a[1] = busy1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic [7:0] pic_b[2][3];
  logic       pic_e[2][3];

  always #5 clock = ~clock;

  interrupt_acknowledge_sequencer #(.PULSE_CYCLES(2), .GAP_CYCLES(2), .MODE_8086(1)) u_86 (
    .clock(clock), .reset_n(reset_n), .interrupt_to_cpu(int_in[0]),
    .interrupt_enable(int_en), .interrupt_acknowledge_n(inta0),
    .data_bus_in(din[0]), .data_bus_io(io[0]), .vector_valid(valid0),
    .vector_ready(ready[0]), .vector(vec0), .vector_address(addr0),
    .vector_error(err0), .busy(busy0)
  );

  interrupt_acknowledge_sequencer #(.PULSE_CYCLES(2), .GAP_CYCLES(2), .MODE_8086(0)) u_80 (
    .clock(clock), .reset_n(reset_n), .interrupt_to_cpu(int_in[1]),
    .interrupt_enable(int_en), .interrupt_acknowledge_n(inta1),
    .data_bus_in(din[1]), .data_bus_io(io[1]), .vector_valid(valid1),
    .vector_ready(ready[1]), .vector(vec1), .vector_address(addr1),
    .vector_error(err1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // PIC model: drives the table byte for the current pulse while INTA is low.
  int  pic_p   [2];
  logic pic_prv[2];
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!busy_a[i]) pic_p[i] = 0;
      if (inta_a[i] === 1'b0) begin
        din[i] = pic_b[i][pic_p[i]];
        io[i]  = pic_e[i][pic_p[i]];
      end else begin
        if (pic_prv[i] === 1'b0 && pic_p[i] < 2) pic_p[i] = pic_p[i] + 1;
        din[i] = 8'hEE;
        io[i]  = 1'b1;
      end
      pic_prv[i] = inta_a[i];
    end
  end

  // Monitor: pulse/gap widths, valid run length, scoreboard pop on transfer.
  int   lrun[2], hrun[2], np[2], vr[2];
  logic prv [2];
  always @(negedge clock) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        lrun[i] = 0; hrun[i] = 0; np[i] = 0; vr[i] = 0; prv[i] = 1'b1;
      end else begin
        if (inta_a[i] === 1'b0) begin
          if (prv[i] === 1'b1 && np[i] > 0) check("gap_width", hrun[i], 2);
          lrun[i] = lrun[i] + 1;
          hrun[i] = 0;
        end else begin
          if (prv[i] === 1'b0) begin
            check("pulse_width", lrun[i], 2);
            np[i] = np[i] + 1;
            lrun[i] = 0;
          end
          hrun[i] = hrun[i] + 1;
        end
        prv[i] = inta_a[i];
        if (valid_a[i] === 1'b1) vr[i] = vr[i] + 1;
        if (valid_a[i] === 1'b1 && ready[i] === 1'b1) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_vector: instance %0d presented a result with none expected", i);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            check("sb_vector",  (i == 0) ? vec0 : vec1,   e.vec);
            check("sb_address", (i == 0) ? addr0 : addr1, e.addr);
            check("sb_error",   (i == 0) ? err0 : err1,   e.err);
            check("sb_pulses",  np[i], e.pulses);
            check("sb_valid_cycles", vr[i], e.vrun);
          end
          np[i] = 0;
          vr[i] = 0;
        end
      end
    end
  end

  function automatic logic get_sig(input int i, input int sel);
    case (sel)
      0:       return busy_a[i];
      1:       return inta_a[i];
      default: return valid_a[i];
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_for(input int i, input int sel, input logic lvl, input string name);
    for (int k = 0; k < 60; k++) begin
      if (get_sig(i, sel) === lvl) return;
      step();
    end
    n_checks++;
    n_fail++;
    $display("FAIL timeout_%s: signal never reached %0b", name, lvl);
  endtask

  task automatic set_pic(input int i, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic e0, input logic e1, input logic e2);
    pic_b[i][0] = b0; pic_b[i][1] = b1; pic_b[i][2] = b2;
    pic_e[i][0] = e0; pic_e[i][1] = e1; pic_e[i][2] = e2;
  endtask

  task automatic push(input int i, input logic [7:0] v, input logic [15:0] a,
                      input logic er, input int p, input int vrun);
    exp_t e;
    e.vec = v; e.addr = a; e.err = er; e.pulses = p; e.vrun = vrun;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic run_seq(input int i);
    int_in[i] = 1'b1;
    wait_for(i, 0, 1'b1, "busy");
    int_in[i] = 1'b0;
    wait_for(i, 0, 1'b0, "idle");
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_inta"},  {inta0, inta1},   2'b11);
    check({tag, "_valid"}, {valid0, valid1}, 2'b00);
    check({tag, "_busy"},  {busy0, busy1},   2'b00);
    check({tag, "_err"},   {err0, err1},     2'b00);
    check({tag, "_vec"},   {vec0, vec1},     16'h0000);
    check({tag, "_addr"},  {addr0, addr1},   32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int_in[0] = 1'b0; int_in[1] = 1'b0;
    ready[0]  = 1'b1; ready[1]  = 1'b1;
    set_pic(0, 8'hEE, 8'hEE, 8'hEE, 1'b1, 1'b1, 1'b1);
    set_pic(1, 8'hEE, 8'hEE, 8'hEE, 1'b1, 1'b1, 1'b1);
    repeat (3) step();
    check_reset_values("reset");
    reset_n = 1'b1;
    int_en  = 1'b1;
    repeat (2) step();

    // 8086 latency: INTA low after E2..E3 and E6..E7, valid after E8.
    set_pic(0, 8'hFF, 8'h4A, 8'h00, 1'b1, 1'b0, 1'b0);
    push(0, 8'h4A, 16'h0000, 1'b0, 2, 1);
    int_in[0] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      check("lat_inta", inta0, (k == 2 || k == 3 || k == 6 || k == 7) ? 1'b0 : 1'b1);
      check("lat_valid", valid0, (k == 8) ? 1'b1 : 1'b0);
      if (k == 6) int_in[0] = 1'b0;
    end
    wait_for(0, 0, 1'b0, "idle_lat");

    // Enable low blocks any start on either instance.
    int_en = 1'b0;
    int_in[0] = 1'b1; int_in[1] = 1'b1;
    repeat (12) begin
      step();
      check("gate_busy", {busy0, busy1, inta0, inta1}, 4'b0011);
    end
    int_in[0] = 1'b0; int_in[1] = 1'b0;
    repeat (4) step();
    int_en = 1'b1;

    // INT and enable drop during the first pulse: the sequence still completes.
    set_pic(0, 8'hFF, 8'h21, 8'h00, 1'b1, 1'b0, 1'b0);
    push(0, 8'h21, 16'h0000, 1'b0, 2, 1);
    int_in[0] = 1'b1;
    wait_for(0, 1, 1'b0, "inta_low");
    int_in[0] = 1'b0;
    int_en = 1'b0;
    wait_for(0, 0, 1'b0, "idle_abort");
    int_en = 1'b1;

    // Bus error on the sampling edge, then a clean sequence clears it.
    set_pic(0, 8'hFF, 8'h77, 8'h00, 1'b1, 1'b1, 1'b0);
    push(0, 8'h77, 16'h0000, 1'b1, 2, 1);
    run_seq(0);
    set_pic(0, 8'hFF, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0);
    push(0, 8'h55, 16'h0000, 1'b0, 2, 1);
    run_seq(0);

    // Backpressure: result held for 10 cycles, restart one cycle after transfer.
    ready[0] = 1'b0;
    set_pic(0, 8'hFF, 8'h9C, 8'h00, 1'b1, 1'b0, 1'b0);
    push(0, 8'h9C, 16'h0000, 1'b0, 2, 11);
    int_in[0] = 1'b1;
    wait_for(0, 2, 1'b1, "valid_bp");
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", valid0, 1'b1);
      check("bp_vector", vec0, 8'h9C);
      check("bp_inta", inta0, 1'b1);
      step();
    end
    set_pic(0, 8'hFF, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0);
    push(0, 8'hA5, 16'h0000, 1'b0, 2, 1);
    ready[0] = 1'b1;
    step();
    check("bp_xfer_busy", busy0, 1'b0);
    check("bp_xfer_inta", inta0, 1'b1);
    step();
    check("bp_restart_inta", inta0, 1'b0);
    int_in[0] = 1'b0;
    wait_for(0, 0, 1'b0, "idle_bp");

    // Reset in the middle of the second pulse forces INTA high at once.
    set_pic(0, 8'hFF, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0);
    int_in[0] = 1'b1;
    wait_for(0, 1, 1'b0, "inta_p0");
    wait_for(0, 1, 1'b1, "inta_gap");
    wait_for(0, 1, 1'b0, "inta_p1");
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    int_in[0] = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    set_pic(0, 8'hFF, 8'h66, 8'h00, 1'b1, 1'b0, 1'b0);
    push(0, 8'h66, 16'h0000, 1'b0, 2, 1);
    run_seq(0);

    // 8080 CALL sequence, result held until ready.
    ready[1] = 1'b0;
    set_pic(1, 8'hCD, 8'h34, 8'h12, 1'b0, 1'b0, 1'b0);
    push(1, 8'hCD, 16'h1234, 1'b0, 3, 4);
    int_in[1] = 1'b1;
    wait_for(1, 2, 1'b1, "valid80");
    int_in[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("hold80_valid", valid1, 1'b1);
      check("hold80_addr", addr1, 16'h1234);
      step();
    end
    ready[1] = 1'b1;
    wait_for(1, 0, 1'b0, "idle80");

    // 8080 error on the third byte, then a clean sequence.
    set_pic(1, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b1);
    push(1, 8'h11, 16'h3322, 1'b1, 3, 1);
    run_seq(1);
    set_pic(1, 8'hAB, 8'hCD, 8'hEF, 1'b0, 1'b0, 1'b0);
    push(1, 8'hAB, 16'hEFCD, 1'b0, 3, 1);
    run_seq(1);

    repeat (5) step();
    check("sb_drained_86", q0.size(), 0);
    check("sb_drained_80", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
